xpb_table_gen: RTL
==================

Name: xpb_table_gen

Overview:
- Runtime-configurable successor to the fixed xpb constant ROMs used by the modular squaring datapath.
- Instead of hard-coded entries, it computes table[j] = (j * BASE) mod MOD for j = 0 .. 2^IDX_BITS-1. The fill uses a sequential modular-add engine after a configuration handshake.
- Once filled, it serves NUM_CH independent registered lookups per cycle, feeding the xpb reduction adders.

Parameters:
- WORD_BITS, 1024: table entry width, also the BASE/MOD width.
- IDX_BITS, 5: index width; depth is 2^IDX_BITS.
- NUM_CH, 1: number of parallel read channels.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted
- cfg_base  in  WORD_BITS  multiplicand BASE; must satisfy BASE < MOD
- cfg_mod  in  WORD_BITS  modulus MOD; nonzero
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when the fill completes
- table_valid  out  1  table contents are valid for reads
- rd_valid  in  NUM_CH  per-channel read request
- rd_idx  in  NUM_CH*IDX_BITS  per-channel index; channel c occupies bits [c*IDX_BITS +: IDX_BITS]
- rd_data  out  NUM_CH*WORD_BITS  per-channel entry, same slicing
- rd_data_valid  out  NUM_CH  per-channel result valid

Behaviour:
- Reset values: FSM state IDLE; cfg_ready=1, busy=0, done=0, table_valid=0, rd_data=0, rd_data_valid=0, fill counter=0, accumulator=0.
- Storage: the table array itself is not reset. Its contents are meaningless while table_valid=0.
- FSM states and transitions:
  - IDLE: a cfg fire (cfg_valid & cfg_ready) latches BASE and MOD, writes table[0]=0, clears acc, sets j=1 and moves to FILL.
  - FILL: each cycle computes s = acc + BASE at WORD_BITS+1 bits. If s >= MOD then acc_n = s - MOD, else acc_n = s; acc_n is truncated to WORD_BITS. The engine writes table[j]=acc_n, sets acc=acc_n and increments j. When j = 2^IDX_BITS-1 it moves to READY and pulses done in the following cycle. The fill takes exactly 2^IDX_BITS-1 cycles after the cfg fire cycle.
  - READY: table_valid=1. A cfg fire here reconfigures: table_valid drops in the next cycle and the FSM enters FILL exactly as from IDLE.
- cfg_ready is 0 in FILL and 1 otherwise; busy=1 exactly while in FILL. cfg_valid during FILL is ignored (no fire).
- Arithmetic:
  - A single conditional subtract suffices because acc < MOD and BASE < MOD.
  - If software violates BASE < MOD, the results are undefined but the FSM still terminates after 2^IDX_BITS-1 cycles.
- Reads:
  - In any cycle with table_valid=1, channel c with rd_valid[c]=1 registers rd_data[c] = table[rd_idx[c]] and sets rd_data_valid[c]=1 at the next edge. Latency is 1 cycle, full throughput, and channels are independent; identical indices on several channels are allowed.
  - With rd_valid[c]=0 or table_valid=0: rd_data_valid[c]=0 next cycle and rd_data[c] holds its previous value.
  - A read in the same cycle as a cfg fire from READY is served from the old contents, since table_valid is still 1 in that cycle.
- Reset mid-fill: the FSM returns to IDLE immediately and table_valid=0. A new cfg is required before reads are served again.
- Index 0 always returns 0 after any completed fill.

Decomposition:
- Package xpb_pkg holds:
  - the FSM state enum (IDLE, FILL, READY);
  - localparam DEPTH = 2**IDX_BITS;
  - the per-channel slice helper convention.
- One natural combinational sub-module, xpb_mod_add (WORD_BITS parameter): inputs a, b, m; output (a+b) mod m, under the precondition a, b < m.
- The table array and read registers live in the top module.

Test Plan:
- Small config (WORD_BITS=16, IDX_BITS=3, NUM_CH=2), BASE=5, MOD=13 → busy high for 7 cycles, done pulses once. Reads of idx 0..7 return 0,5,10,2,7,12,4,9 with 1-cycle latency.
- Dual-channel read in the same cycle, ch0 idx=5 and ch1 idx=5, then ch0 idx=7 and ch1 idx=2 → next cycle {12,12}, then {9,10}, with both rd_data_valid bits high.
- Read before any cfg, and cfg_valid asserted during FILL → rd_data_valid stays 0, rd_data stays 0, cfg_ready=0 throughout FILL, and the second config is not latched.
- Reconfigure from READY with BASE=3, MOD=7 while reading idx 3 in the same cycle:
  - that read returns 2 from the old table;
  - table_valid drops the next cycle;
  - after the new fill, idx 0..7 return 0,3,6,2,5,1,4,0.
- Assert rst_n low at fill cycle 3 → all outputs return to reset values asynchronously. After release, reads are not served until a new cfg fill completes.
- Default config (1024/5/1) with MOD = 2^1023+1 and BASE = MOD-1 → every entry j equals (MOD-j) mod MOD, i.e. table[1] = MOD-1 and table[31] = MOD-31. This checks the subtract path at full width against a golden reference model.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared types and helpers for the runtime-configurable xpb table generator.
//   xpb_state_e : fill engine state (IDLE, FILL, READY)
//   DEPTH       : table depth for the default index width
//   xpb_depth   : table depth for a given index width
//   ch_lsb      : LSB of channel ch inside a flattened per-channel bus
package xpb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } xpb_state_e;

    localparam int unsigned DEF_WORD_BITS = 1024;
    localparam int unsigned DEF_IDX_BITS  = 5;
    localparam int unsigned DEF_NUM_CH    = 1;
    localparam int unsigned DEPTH         = 2 ** DEF_IDX_BITS;

    function automatic int unsigned xpb_depth(input int unsigned idx_bits);
        return 32'(1) << idx_bits;
    endfunction

    // Channel c of a flattened bus occupies [c*w +: w]
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/xpb_mod_add.sv
// Combinational modular adder: sum_c = (a + b) mod m, valid when a < m and b < m.
//   a, b  : addends (WORD_BITS)
//   m     : modulus (WORD_BITS)
//   sum_c : result (WORD_BITS)
module xpb_mod_add #(
    parameter int unsigned WORD_BITS = 1024
) (
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b,
    input  logic [WORD_BITS-1:0] m,
    output logic [WORD_BITS-1:0] sum_c
);

    logic [WORD_BITS:0] s_c;
    logic [WORD_BITS:0] d_c;

    // One extra bit keeps the carry so the compare against m is exact
    assign s_c   = {1'b0, a} + {1'b0, b};
    assign d_c   = s_c - {1'b0, m};
    assign sum_c = (s_c >= {1'b0, m}) ? WORD_BITS'(d_c) : WORD_BITS'(s_c);

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime-configurable xpb table: table[j] = (j * BASE) mod MOD, filled by a
// sequential modular-add engine, then served on NUM_CH registered read ports.
//   cfg_valid/cfg_ready/cfg_base/cfg_mod : configuration handshake
//   busy, done, table_valid              : fill status
//   rd_valid/rd_idx                      : per-channel read request
//   rd_data/rd_data_valid                : per-channel result, 1-cycle latency
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int unsigned WORD_BITS = DEF_WORD_BITS,
    parameter int unsigned IDX_BITS  = DEF_IDX_BITS,
    parameter int unsigned NUM_CH    = DEF_NUM_CH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [WORD_BITS-1:0]          cfg_base,
    input  logic [WORD_BITS-1:0]          cfg_mod,
    output logic                          busy,
    output logic                          done,
    output logic                          table_valid,
    input  logic [NUM_CH-1:0]             rd_valid,
    input  logic [NUM_CH*IDX_BITS-1:0]    rd_idx,
    output logic [NUM_CH*WORD_BITS-1:0]   rd_data,
    output logic [NUM_CH-1:0]             rd_data_valid
);

    localparam int unsigned          TBL_DEPTH = xpb_depth(IDX_BITS);
    localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(TBL_DEPTH - 1);

    xpb_state_e           state, state_n;
    logic [WORD_BITS-1:0] base_q, base_n;
    logic [WORD_BITS-1:0] mod_q, mod_n;
    logic [WORD_BITS-1:0] acc_q, acc_n;
    logic [IDX_BITS-1:0]  j_q, j_n;
    logic                 cfg_ready_n, busy_n, done_n, table_valid_n;

    logic                 cfg_fire_c;
    logic [WORD_BITS-1:0] acc_sum_c;
    logic                 wr_en_c;
    logic [IDX_BITS-1:0]  wr_idx_c;
    logic [WORD_BITS-1:0] wr_data_c;

    logic [WORD_BITS-1:0] tbl [TBL_DEPTH];

    assign cfg_fire_c = cfg_valid & cfg_ready;

    xpb_mod_add #(
        .WORD_BITS (WORD_BITS)
    ) u_mod_add (
        .a     (acc_q),
        .b     (base_q),
        .m     (mod_q),
        .sum_c (acc_sum_c)
    );

    // Next-state, engine datapath and table write port
    always_comb begin
        state_n       = state;
        base_n        = base_q;
        mod_n         = mod_q;
        acc_n         = acc_q;
        j_n           = j_q;
        cfg_ready_n   = cfg_ready;
        busy_n        = busy;
        done_n        = 1'b0;
        table_valid_n = table_valid;
        wr_en_c       = 1'b0;
        wr_idx_c      = '0;
        wr_data_c     = '0;
        case (state)
            IDLE, READY: begin
                if (cfg_fire_c) begin
                    state_n       = FILL;
                    base_n        = cfg_base;
                    mod_n         = cfg_mod;
                    acc_n         = '0;
                    j_n           = IDX_BITS'(1);
                    cfg_ready_n   = 1'b0;
                    busy_n        = 1'b1;
                    table_valid_n = 1'b0;
                    wr_en_c       = 1'b1;
                end
            end
            FILL: begin
                wr_en_c   = 1'b1;
                wr_idx_c  = j_q;
                wr_data_c = acc_sum_c;
                acc_n     = acc_sum_c;
                j_n       = j_q + IDX_BITS'(1);
                if (j_q == LAST_IDX) begin
                    state_n       = READY;
                    cfg_ready_n   = 1'b1;
                    busy_n        = 1'b0;
                    done_n        = 1'b1;
                    table_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            mod_q       <= '0;
            acc_q       <= '0;
            j_q         <= '0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            mod_q       <= mod_n;
            acc_q       <= acc_n;
            j_q         <= j_n;
            cfg_ready   <= cfg_ready_n;
            busy        <= busy_n;
            done        <= done_n;
            table_valid <= table_valid_n;
        end
    end

    // Table storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            tbl[wr_idx_c] <= wr_data_c;
        end
    end

    // Read ports; a read in a reconfigure cycle still sees the old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= '0;
            rd_data_valid <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                rd_data_valid[c] <= rd_valid[c] & table_valid;
                if (rd_valid[c] & table_valid) begin
                    rd_data[ch_lsb(c, WORD_BITS) +: WORD_BITS] <=
                        tbl[rd_idx[ch_lsb(c, IDX_BITS) +: IDX_BITS]];
                end
            end
        end
    end

endmodule
